ascon_ti_sbox_sched: RTL
========================

Name: ascon_ti_sbox_sched

Overview:
- Sequencer for the 3-share threshold-implementation (TI) Ascon substitution layer.
- Accepts a masked 320-bit state as three shares and walks it column by column through COLS_PER_CYCLE TI S-box slices.
- Registers the TI outputs as a glitch barrier, re-masks them with fresh randomness, and writes them back in place.
- Sits between the masked permutation round controller (constant-add layer upstream, linear layer downstream) and the TRNG/PRNG randomness source.

Parameters:
- COLS_PER_CYCLE, 4, S-box columns processed per issue cycle; must divide 64 (legal values 1, 2, 4, 8, 16).
- RAND_EN, 1, 1 = re-mask each slice with fresh randomness; 0 = no re-masking, randomness port unused.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input shares valid
- in_ready  out  1  block can accept a state
- in_s0  in  320  input share 0 (x0=[319:256], x1=[255:192], x2=[191:128], x3=[127:64], x4=[63:0])
- in_s1  in  320  input share 1
- in_s2  in  320  input share 2
- rnd_valid  in  1  fresh randomness valid
- rnd_ready  out  1  randomness consumed this cycle when rnd_valid is also high
- rnd  in  10*COLS_PER_CYCLE  fresh mask bits; r_a = low half, r_b = high half
- out_valid  out  1  substituted shares valid
- out_ready  in  1  downstream accepts result
- out_s0  out  320  output share 0
- out_s1  out  320  output share 1
- out_s2  out  320  output share 2
- busy  out  1  high in RUN, DRAIN and DONE

Interface: single clock clk; rst is synchronous, active-high.

Behaviour:
- Column j (0..63) = {x0[j], x1[j], x2[j], x3[j], x4[j]} of each share. Slice k covers columns k*C .. k*C+C-1, where C = COLS_PER_CYCLE. NSLICE = 64/C. Slices are issued in ascending k.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready=1. On in_valid: capture the three shares into the share registers, cnt=0, go to RUN.
  - RUN: an issue happens when (RAND_EN=0) or rnd_valid.
    - On issue: slice cnt of all three shares feeds the TI slice. The outputs are XORed with the masks: y0^r_a, y1^r_b, y2^(r_a^r_b). The result is captured into the pipe register with pipe_valid=1 and pipe_idx=cnt. cnt increments.
    - With no issue: pipe_valid=0 (bubble) and cnt holds.
    - After issuing cnt=NSLICE-1, go to DRAIN.
  - DRAIN: the last pipe entry is written back, then go to DONE.
  - DONE: out_valid=1, out_s* = share registers. On out_ready: clear all share registers and go to IDLE.
- Write-back: whenever pipe_valid=1, write the pipe contents into columns pipe_idx of the share registers on the next edge. Read and write slices always differ, so there is no hazard.
- rnd_ready = RAND_EN & (state==RUN). With RAND_EN=0, rnd_ready is tied to 0 and rnd is ignored.
- Latency, with no randomness stalls: in accepted at edge E0, out_valid high after edge E(NSLICE+1). For C=4 that is 17 cycles. Each rnd stall cycle adds exactly one cycle.
- out_s0/1/2 are forced to 0 whenever out_valid=0, so no intermediate shares appear on outputs.
- Only one state in flight at a time. in_ready=0 in all states except IDLE.
- Backpressure: in DONE with out_ready=0, outputs and registers hold indefinitely.
- Reset values, on rst in any state including mid-RUN: state=IDLE, cnt=0, pipe_valid=0, pipe register=0, all share registers=0. Resulting outputs: in_ready=1, out_valid=0, rnd_ready=0, busy=0, out_s*=0.
- The unmasked value (s0^s1^s2) per column equals the Ascon S-box of the input column, independent of masks and randomness.

Decomposition:
- Package ascon_ti_pkg holds:
  - NUM_SHARES=3, STATE_W=320, LANE_W=64, SBOX_W=5.
  - typedef share_state_t (320 bits) and typedef ti_col_t (5 bits).
  - FSM state enum.
  - Function col_idx(lane, j) mapping lane/column to a state bit.
- Sub-module ascon_ti_sbox_slice:
  - Takes C columns of three shares and produces three output shares.
  - Instantiates the three existing TI component functions, one per output share, C times.

Test Plan:
- All-zero shares (0,0,0), RAND_EN=1, random rnd -> recombined output has x2 lane=0xFFFFFFFFFFFFFFFF and other lanes 0 (S-box(0)=0x04).
- Accept at E0 with rnd_valid held 1 and C=4 -> out_valid rises after E17, busy high E1..E17, in_ready low until the cycle after out handshake.
- Same stimulus with rnd_valid dropped for 5 cycles at slice 6 -> out_valid after E22, recombined result bit-identical to the unstalled run.
- Random 320-bit state split with two different mask sets -> recombined outputs both equal the golden unmasked Ascon S-box model, and individual output shares differ between runs.
- out_ready low for 10 cycles in DONE -> out_s* stable and in_ready=0; after handshake, out_s*=0 and in_ready=1 next cycle, and a new state is accepted correctly.
- rst asserted during RUN at cnt=7 -> next cycle state IDLE, in_ready=1, out_valid=0, rnd_ready=0, all share registers 0; a subsequent operation yields correct S-box output.

Source files
------------

// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg: shared types and the 3-share TI component function for the Ascon S-box
package ascon_ti_pkg;
  localparam int NUM_SHARES = 3;
  localparam int STATE_W = 320;
  localparam int LANE_W = 64;
  localparam int SBOX_W = 5;
  localparam int IDX_W = $clog2(STATE_W);
  typedef logic [STATE_W-1:0] share_state_t;
  typedef logic [SBOX_W-1:0] ti_col_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  function automatic logic [IDX_W-1:0] col_idx(int lane, int j);
    return IDX_W'((SBOX_W - 1 - lane) * LANE_W + j);
  endfunction
  // column bit 4 is x0, bit 0 is x4; result vector is lane-indexed (bit l = x_l)
  function automatic logic [4:0] lin_in(ti_col_t c);
    return {c[0] ^ c[1], c[1], c[2] ^ c[3], c[3], c[4] ^ c[0]};
  endfunction
  // output share from input shares a (linear + own quadratic) and b (cross terms); inv carries ~x2
  function automatic ti_col_t ti_f(ti_col_t a, ti_col_t b, logic inv);
    logic [4:0] p, q, p1, p2, q1, q2, y;
    p = lin_in(a);
    q = lin_in(b);
    p1 = {p[0], p[4:1]};
    p2 = {p[1:0], p[4:2]};
    q1 = {q[0], q[4:1]};
    q2 = {q[1:0], q[4:2]};
    y = p ^ p2 ^ (p1 & p2) ^ (p1 & q2) ^ (q1 & p2);
    return {y[0] ^ y[4], y[1] ^ y[0], y[2] ^ inv, y[3] ^ y[2], y[4]};
  endfunction
endpackage

// File: rtl/ascon_ti_sbox_sched_if.sv
// ascon_ti_sbox_sched_if: share input, randomness and result handshakes of the TI S-box sequencer
interface ascon_ti_sbox_sched_if import ascon_ti_pkg::*; #(parameter int COLS_PER_CYCLE = 4);
  logic in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready, busy;
  share_state_t in_s0, in_s1, in_s2, out_s0, out_s1, out_s2;
  logic [10*COLS_PER_CYCLE-1:0] rnd;
  modport master(output in_valid, in_s0, in_s1, in_s2, rnd_valid, rnd, out_ready,
                 input in_ready, rnd_ready, out_valid, out_s0, out_s1, out_s2, busy);
  modport slave(input in_valid, in_s0, in_s1, in_s2, rnd_valid, rnd, out_ready,
                output in_ready, rnd_ready, out_valid, out_s0, out_s1, out_s2, busy);
endinterface

// File: rtl/ascon_ti_sbox_slice.sv
// ascon_ti_sbox_slice: COLS_PER_CYCLE parallel 3-share TI Ascon S-boxes, non-complete per output share
module ascon_ti_sbox_slice import ascon_ti_pkg::*; #(parameter int COLS_PER_CYCLE = 4) (
  input  ti_col_t [COLS_PER_CYCLE-1:0] x0, x1, x2,
  output ti_col_t [COLS_PER_CYCLE-1:0] y0, y1, y2
);
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign y0[i] = ti_f(x1[i], x2[i], 1'b1);
    assign y1[i] = ti_f(x2[i], x0[i], 1'b0);
    assign y2[i] = ti_f(x0[i], x1[i], 1'b0);
  end
endmodule

// File: rtl/ascon_ti_sbox_sched.sv
// ascon_ti_sbox_sched: walks a 3-share Ascon state through TI S-box slices with a re-masked glitch register
module ascon_ti_sbox_sched import ascon_ti_pkg::*; #(
  parameter int COLS_PER_CYCLE = 4,
  parameter bit RAND_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  ascon_ti_sbox_sched_if.slave io
);
  localparam int C = COLS_PER_CYCLE;
  localparam int NSLICE = LANE_W / C;
  localparam int IW = $clog2(NSLICE);
  state_t state;
  logic [IW-1:0] cnt, pipe_idx;
  logic pipe_valid, issue;
  logic [5*C-1:0] r_a, r_b;
  share_state_t s [NUM_SHARES];
  ti_col_t [C-1:0] x [NUM_SHARES];
  ti_col_t [C-1:0] y [NUM_SHARES];
  ti_col_t [C-1:0] pipe [NUM_SHARES];
  assign issue = (state == S_RUN) && (!RAND_EN || io.rnd_valid);
  assign r_a = RAND_EN ? io.rnd[5*C-1:0] : '0;
  assign r_b = RAND_EN ? io.rnd[10*C-1:5*C] : '0;
  always_comb begin
    x = '{default: '0};
    for (int i = 0; i < NUM_SHARES; i++)
      for (int t = 0; t < C; t++)
        for (int b = 0; b < SBOX_W; b++)
          x[i][t][b] = s[i][col_idx(SBOX_W - 1 - b, int'(cnt) * C + t)];
  end
  ascon_ti_sbox_slice #(.COLS_PER_CYCLE(C)) u_slice (
    .x0(x[0]), .x1(x[1]), .x2(x[2]),
    .y0(y[0]), .y1(y[1]), .y2(y[2])
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      pipe_idx <= '0;
      pipe_valid <= 1'b0;
      pipe <= '{default: '0};
      s <= '{default: '0};
    end else begin
      pipe_valid <= issue;
      if (issue) begin
        pipe[0] <= y[0] ^ r_a;
        pipe[1] <= y[1] ^ r_b;
        pipe[2] <= y[2] ^ r_a ^ r_b;
        pipe_idx <= cnt;
        cnt <= cnt + 1'b1;
      end
      // the slice being written back is always the one issued last cycle, never the one being read
      if (pipe_valid)
        for (int i = 0; i < NUM_SHARES; i++)
          for (int t = 0; t < C; t++)
            for (int b = 0; b < SBOX_W; b++)
              s[i][col_idx(SBOX_W - 1 - b, int'(pipe_idx) * C + t)] <= pipe[i][t][b];
      if (state == S_IDLE && io.in_valid) begin
        state <= S_RUN;
        cnt <= '0;
        s <= '{io.in_s0, io.in_s1, io.in_s2};
      end else if (issue && cnt == IW'(NSLICE - 1)) state <= S_DRAIN;
      else if (state == S_DRAIN) state <= S_DONE;
      else if (state == S_DONE && io.out_ready) begin
        state <= S_IDLE;
        s <= '{default: '0};
      end
    end
  end
  assign io.in_ready = state == S_IDLE;
  assign io.rnd_ready = RAND_EN && state == S_RUN;
  assign io.out_valid = state == S_DONE;
  assign io.busy = state != S_IDLE;
  assign io.out_s0 = io.out_valid ? s[0] : '0;
  assign io.out_s1 = io.out_valid ? s[1] : '0;
  assign io.out_s2 = io.out_valid ? s[2] : '0;
endmodule
